// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial in_1 - in_2 - bin, LSB first, one full-subtractor cell plus a borrow flop
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr, r_b_sr, r_d_sr, r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_br, r_busy, r_done, r_bout;
    logic             w_a0, w_b0, w_d, w_bnext, w_last;
    logic [WIDTH-1:0] w_d_next;
    assign w_a0     = r_a_sr[0];
    assign w_b0     = r_b_sr[0];
    assign w_d      = w_a0 ^ w_b0 ^ r_br;
    assign w_bnext  = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
    assign w_d_next = {w_d, r_d_sr[WIDTH-1:1]};
    assign w_last   = r_cnt == LAST;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_d_sr  <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state <= SHIFT;
                    r_busy  <= 1'b1;
                    r_a_sr  <= in_1;
                    r_b_sr  <= in_2;
                    r_br    <= bin;
                    r_cnt   <= '0;
                    r_d_sr  <= '0;
                end
                SHIFT: begin
                    r_br   <= w_bnext;
                    r_d_sr <= w_d_next;
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_cnt  <= r_cnt + 1'b1;
                    // final bit: publish the result on the same edge the last bit is formed
                    if (w_last) begin
                        r_state <= DONE;
                        r_diff  <= w_d_next;
                        r_bout  <= w_bnext;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors plus held-start sweeps for WIDTH=8 and WIDTH=32
module tb_serial_subtractor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8 = 1'b0, bin8 = 1'b0, busy8, done8, bout8;
    logic [7:0]  in8_1 = '0, in8_2 = '0, diff8;
    logic        start32 = 1'b0, bin32 = 1'b0, busy32, done32, bout32;
    logic [31:0] in32_1 = '0, in32_2 = '0, diff32;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start8), .in_1(in8_1), .in_2(in8_2),
        .bin(bin8), .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));
    serial_subtractor #(.WIDTH(32)) dut32 (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start32), .in_1(in32_1), .in_2(in32_2),
        .bin(bin32), .busy(busy32), .done(done32), .diff(diff32), .bout(bout32));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          input logic [7:0] ed, input logic eb, input string tag);
        int n = 0;
        int nb = 1;
        @(negedge clk);
        in8_1 = a; in8_2 = b; bin8 = bi; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; in8_1 = ~a; in8_2 = ~b; bin8 = ~bi;
        chk({tag, "_busy_k"}, 64'(busy8), 64'd1);
        while (!done8 && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (busy8) nb++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd8);
        chk({tag, "_busy_cycles"}, 64'(nb), 64'd9);
        chk({tag, "_diff"}, 64'(diff8), 64'(ed));
        chk({tag, "_bout"}, 64'(bout8), 64'(eb));
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, 64'(done8), 64'd0);
        chk({tag, "_busy_drop"}, 64'(busy8), 64'd0);
    endtask

    task automatic sweep(input int w, input int nops);
        logic [63:0] mask, a, b, r, ed, eb;
        logic        bi, pb, bsy, dn;
        int          cyc = 0, ops = 0, last = -1;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 1);
        a = {$urandom, $urandom} & mask; b = {$urandom, $urandom} & mask; bi = 1'($urandom);
        ed = '0; eb = '0;
        @(negedge clk);
        if (w == 8) begin in8_1 = a[7:0]; in8_2 = b[7:0]; bin8 = bi; start8 = 1'b1; end
        else begin in32_1 = a[31:0]; in32_2 = b[31:0]; bin32 = bi; start32 = 1'b1; end
        pb = 1'b0;
        while (ops < nops && cyc < nops * (w + 2) + 50) begin
            @(posedge clk); #1;
            cyc++;
            bsy = (w == 8) ? busy8 : busy32;
            dn  = (w == 8) ? done8 : done32;
            if (bsy && !pb) begin
                r  = a - b - 64'(bi);
                ed = r & mask;
                eb = 64'(r[63]);
                a = {$urandom, $urandom} & mask; b = {$urandom, $urandom} & mask; bi = 1'($urandom);
                if (w == 8) begin in8_1 = a[7:0]; in8_2 = b[7:0]; bin8 = bi; end
                else begin in32_1 = a[31:0]; in32_2 = b[31:0]; bin32 = bi; end
            end
            if (dn) begin
                chk($sformatf("sweep%0d_diff", w), (w == 8) ? 64'(diff8) : 64'(diff32), ed);
                chk($sformatf("sweep%0d_bout", w), (w == 8) ? 64'(bout8) : 64'(bout32), eb);
                if (last >= 0) chk($sformatf("sweep%0d_spacing", w), 64'(cyc - last), 64'(w + 2));
                last = cyc;
                ops++;
            end
            pb = bsy;
        end
        chk($sformatf("sweep%0d_ops", w), 64'(ops), 64'(nops));
        start8 = 1'b0; start32 = 1'b0;
        repeat (w + 4) @(posedge clk);
    endtask

    initial begin
        int n, nd, at;
        #2;
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_done", 64'(done8), 64'd0);
        chk("rst_diff", 64'(diff8), 64'd0);
        chk("rst_bout", 64'(bout8), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "t1");
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "t2");
        run_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, "t3");
        run_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, "t4");
        run_op(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, "t5");
        // second start at edge k+3 must be dropped
        @(negedge clk);
        in8_1 = 8'h5A; in8_2 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; in8_1 = 8'h01; in8_2 = 8'h02; bin8 = 1'b1;
        nd = 0; at = -1;
        for (int c = 1; c <= 16; c++) begin
            if (c == 3) start8 = 1'b1;
            @(posedge clk); #1;
            start8 = 1'b0;
            if (done8) begin nd++; if (at < 0) at = c; end
        end
        chk("ign_done_count", 64'(nd), 64'd1);
        chk("ign_done_edge", 64'(at), 64'd8);
        chk("ign_diff", 64'(diff8), 64'h1E);
        chk("ign_bout", 64'(bout8), 64'd0);
        // async reset between edges k+4 and k+5
        @(negedge clk);
        in8_1 = 8'h20; in8_2 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy8), 64'd0);
        chk("arst_done", 64'(done8), 64'd0);
        chk("arst_diff", 64'(diff8), 64'd0);
        chk("arst_bout", 64'(bout8), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (done8 || busy8) nd++;
        end
        chk("arst_no_done", 64'(nd), 64'd0);
        run_op(8'h20, 8'h01, 1'b0, 8'h1F, 1'b0, "post_rst");
        sweep(8, 120);
        sweep(32, 60);
        n = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
